// File: rtl/conv2d_channel_acc.sv
// Multi-input-channel conv2d output engine: one KH*KW window beat per input channel, KERNEL_NUM
// parallel MACs, bias, arithmetic-shift requantisation, saturation. Optional ReLU: CONV2D_ACC_RELU_EN.
module conv2d_channel_acc #(
  parameter int unsigned BITWIDTH    = 8,
  parameter int unsigned KERNEL_H    = 3,
  parameter int unsigned KERNEL_W    = 3,
  parameter int unsigned IN_CHANNELS = 4,
  parameter int unsigned KERNEL_NUM  = 2,
  parameter int unsigned ACC_WIDTH   = 32,
  parameter int unsigned OUT_SHIFT   = 0
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          start,
  output logic                                          busy,
  output logic                                          done,
  input  logic [KERNEL_NUM*ACC_WIDTH-1:0]               bias,
  input  logic                                          win_valid,
  output logic                                          win_ready,
  input  logic [KERNEL_H*KERNEL_W*BITWIDTH-1:0]         win_data,
  input  logic [KERNEL_NUM*KERNEL_H*KERNEL_W*BITWIDTH-1:0] wgt_data,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [KERNEL_NUM*2*BITWIDTH-1:0]              out_data
);

  localparam int unsigned K    = KERNEL_H * KERNEL_W;
  localparam int unsigned OW   = 2 * BITWIDTH;
  localparam int unsigned CntW = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
  localparam logic [CntW-1:0] LastCh = CntW'(IN_CHANNELS - 1);

  // Output range expressed at accumulator width; assumes ACC_WIDTH >= 2*BITWIDTH.
  localparam logic signed [ACC_WIDTH-1:0] SatMax = {{(ACC_WIDTH-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SatMin = {{(ACC_WIDTH-OW+1){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StAccum, StFinal, StOutput} state_e;

  state_e                        state_q, state_d;
  logic [CntW-1:0]               ch_cnt_q, ch_cnt_d;
  logic signed [ACC_WIDTH-1:0]   acc_q [KERNEL_NUM];
  logic signed [ACC_WIDTH-1:0]   acc_d [KERNEL_NUM];
  logic [KERNEL_NUM*OW-1:0]      out_data_q, out_data_d;
  logic                          out_valid_q, out_valid_d;
  logic                          done_q, done_d;

  logic signed [ACC_WIDTH-1:0]   beat_sum [KERNEL_NUM];
  logic signed [OW-1:0]          res      [KERNEL_NUM];
  logic                          beat_fire;

  assign busy      = (state_q != StIdle);
  assign win_ready = (state_q == StAccum);
  assign beat_fire = win_valid && (state_q == StAccum);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign done      = done_q;

  // Dot product of the current window with each kernel; sums wrap at accumulator width.
  always_comb begin : mac
    logic signed [BITWIDTH-1:0] a;
    logic signed [BITWIDTH-1:0] w;
    logic signed [OW-1:0]       p;
    a = '0;
    w = '0;
    p = '0;
    beat_sum = '{default: '0};
    for (int k = 0; k < int'(KERNEL_NUM); k++) begin
      for (int i = 0; i < int'(K); i++) begin
        a = win_data[i*BITWIDTH +: BITWIDTH];
        w = wgt_data[(k*K+i)*BITWIDTH +: BITWIDTH];
        p = a * w;
        beat_sum[k] = beat_sum[k] + ACC_WIDTH'(p);
      end
    end
  end

  // Floor shift, clamp to the 2*BITWIDTH signed range, optional ReLU.
  always_comb begin : requant
    logic signed [ACC_WIDTH-1:0] sh;
    sh  = '0;
    res = '{default: '0};
    for (int k = 0; k < int'(KERNEL_NUM); k++) begin
      sh = acc_q[k] >>> OUT_SHIFT;
      if (sh > SatMax) begin
        res[k] = SatMax[OW-1:0];
      end else if (sh < SatMin) begin
        res[k] = SatMin[OW-1:0];
      end else begin
        res[k] = sh[OW-1:0];
      end
`ifdef CONV2D_ACC_RELU_EN
      if (res[k] < 0) begin
        res[k] = '0;
      end
`endif
    end
  end

  always_comb begin : next_state
    state_d     = state_q;
    ch_cnt_d    = ch_cnt_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          for (int k = 0; k < int'(KERNEL_NUM); k++) begin
            acc_d[k] = bias[k*ACC_WIDTH +: ACC_WIDTH];
          end
          ch_cnt_d = '0;
          state_d  = StAccum;
        end
      end
      StAccum: begin
        if (beat_fire) begin
          for (int k = 0; k < int'(KERNEL_NUM); k++) begin
            acc_d[k] = acc_q[k] + beat_sum[k];
          end
          ch_cnt_d = ch_cnt_q + 1'b1;
          if (ch_cnt_q == LastCh) begin
            state_d = StFinal;
          end
        end
      end
      StFinal: begin
        for (int k = 0; k < int'(KERNEL_NUM); k++) begin
          out_data_d[k*OW +: OW] = res[k];
        end
        out_valid_d = 1'b1;
        state_d     = StOutput;
      end
      StOutput: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          done_d      = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ch_cnt_q    <= '0;
      acc_q       <= '{default: '0};
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_cnt_q    <= ch_cnt_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_conv2d_channel_acc.sv
// Bench for conv2d_channel_acc: table of uniform-window vectors plus random pixels, results checked
// through an expected-value queue; a second instance runs with OUT_SHIFT=2 in lockstep.
module tb_conv2d_channel_acc;

  localparam int B   = 8;
  localparam int K   = 9;
  localparam int NCH = 4;
  localparam int KN  = 2;
  localparam int AW  = 32;
  localparam int OW  = 2 * B;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              busy, busy_s2;
  logic              done, done_s2;
  logic [KN*AW-1:0]  bias;
  logic              win_valid;
  logic              win_ready, win_ready_s2;
  logic [K*B-1:0]    win_data;
  logic [KN*K*B-1:0] wgt_data;
  logic              out_valid, out_valid_s2;
  logic              out_ready;
  logic [KN*OW-1:0]  out_data, out_data_s2;

  always #5 clk = ~clk;

  conv2d_channel_acc u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .bias(bias),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data), .wgt_data(wgt_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  conv2d_channel_acc #(.OUT_SHIFT(2)) u_dut_s2 (
    .clk(clk), .rst(rst), .start(start), .busy(busy_s2), .done(done_s2), .bias(bias),
    .win_valid(win_valid), .win_ready(win_ready_s2), .win_data(win_data), .wgt_data(wgt_data),
    .out_valid(out_valid_s2), .out_ready(out_ready), .out_data(out_data_s2)
  );

  typedef struct {
    byte wv; byte w0; byte w1;
    int  b0; int b1;
    int  e0; int e1; int s0; int s1;
    int  gap; int stall; bit hold; bit bb;
  } vec_t;

  typedef struct {
    int e0; int e1; int s0; int s1;
    int stall; bit lat;
  } exp_t;

  vec_t tbl[6];
  exp_t exp_q[$];

  logic [K*B-1:0]    win_mem [NCH];
  logic [KN*K*B-1:0] wgt_mem [NCH];
  logic [KN*AW-1:0]  bias_v;

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  start_cyc = 0;
  bit  mon_en = 1'b0;
  bit  in_wait = 1'b0;
  bit  expect_done = 1'b0;
  int  stall_left = 0;
  logic [KN*OW-1:0] held;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out or no expectation (cycle %0d)", name, cyc);
  endtask

  function automatic int relu(input int v);
`ifdef CONV2D_ACC_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic int model(input int k, input int sh);
    int acc;
    int r;
    acc = int'($signed(bias_v[k*AW +: AW]));
    for (int b = 0; b < NCH; b++) begin
      for (int i = 0; i < K; i++) begin
        acc += int'($signed(win_mem[b][i*B +: B])) * int'($signed(wgt_mem[b][(k*K+i)*B +: B]));
      end
    end
    r = acc >>> sh;
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
    return relu(r);
  endfunction

  task automatic load_uniform(input byte wv, input byte w0, input byte w1, input int b0,
                              input int b1);
    for (int b = 0; b < NCH; b++) begin
      for (int i = 0; i < K; i++) begin
        win_mem[b][i*B +: B]     = wv;
        wgt_mem[b][i*B +: B]     = w0;
        wgt_mem[b][(K+i)*B +: B] = w1;
      end
    end
    bias_v = {b1, b0};
  endtask

  task automatic load_random();
    int b0, b1;
    for (int b = 0; b < NCH; b++) begin
      for (int i = 0; i < K; i++) win_mem[b][i*B +: B] = 8'($urandom_range(0, 255));
      for (int i = 0; i < KN*K; i++) wgt_mem[b][i*B +: B] = 8'($urandom_range(0, 255));
    end
    b0 = int'($urandom_range(0, 4000)) - 2000;
    b1 = int'($urandom_range(0, 4000)) - 2000;
    bias_v = {b1, b0};
  endtask

  task automatic drive_pixel(input int nbeats, input int gap, input bit hold, input bit bb);
    int t;
    bit taken;
    t = 0;
    @(negedge clk);
    while (busy !== 1'b0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) begin
      fail_now("wait_idle");
      return;
    end
    if (bb) chk("b2b_done_cycle", done, 1);
    chk("win_ready_idle", win_ready, 0);
    start     = 1'b1;
    bias      = bias_v;
    start_cyc = cyc;
    win_valid = 1'b1;
    win_data  = win_mem[0];
    wgt_data  = wgt_mem[0];
    @(posedge clk);
    for (int b = 0; b < nbeats; b++) begin
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        win_valid = 1'b0;
        if (!hold) start = 1'b0;
        @(posedge clk);
      end
      t = 0;
      taken = 1'b0;
      while (!taken && t < 50) begin
        @(negedge clk);
        win_valid = 1'b1;
        win_data  = win_mem[b];
        wgt_data  = wgt_mem[b];
        if (!hold) start = 1'b0;
        taken = (win_ready === 1'b1);
        @(posedge clk);
        t++;
      end
      if (!taken) begin
        fail_now("beat_accept");
        win_valid = 1'b0;
        start = 1'b0;
        return;
      end
    end
    @(negedge clk);
    win_valid = 1'b0;
    start     = 1'b0;
  endtask

  task automatic push_model(input int stall);
    exp_t e;
    e.e0 = model(0, 0);
    e.e1 = model(1, 0);
    e.s0 = model(0, 2);
    e.s1 = model(1, 2);
    e.stall = stall;
    e.lat = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || in_wait) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) fail_now("drain");
    repeat (3) @(negedge clk);
  endtask

  // Output side: applies back-pressure and compares results against the queue.
  initial begin
    exp_t cur;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && !rst) begin
        if (expect_done) begin
          chk("done_pulse", done, 1);
          chk("valid_drop", out_valid, 0);
          expect_done = 1'b0;
        end else begin
          chk("done_quiet", done, 0);
        end
        if (out_valid === 1'b1) begin
          chk("win_ready_output", win_ready, 0);
          if (!in_wait) begin
            in_wait = 1'b1;
            held = out_data;
            stall_left = 0;
            if (exp_q.size() != 0) begin
              stall_left = exp_q[0].stall;
              if (exp_q[0].lat) chk("latency", cyc - start_cyc, NCH + 2);
            end
          end else begin
            chk("data_stable", out_data, held);
          end
          if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
          end else begin
            out_ready = 1'b1;
            if (exp_q.size() == 0) begin
              fail_now("unexpected_output");
            end else begin
              cur = exp_q.pop_front();
              chk("k0", int'($signed(out_data[OW-1:0])), cur.e0);
              chk("k1", int'($signed(out_data[2*OW-1:OW])), cur.e1);
              chk("k0_shift2", int'($signed(out_data_s2[OW-1:0])), cur.s0);
              chk("k1_shift2", int'($signed(out_data_s2[2*OW-1:OW])), cur.s1);
            end
            in_wait = 1'b0;
            expect_done = 1'b1;
          end
        end else begin
          out_ready = 1'b1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    tbl[0] = '{wv: 1, w0: 1, w1: -1, b0: 0, b1: 0, e0: 36, e1: -36, s0: 9, s1: -9,
               gap: 0, stall: 0, hold: 0, bb: 0};
    tbl[1] = '{wv: 127, w0: 127, w1: -128, b0: 0, b1: 0, e0: 32767, e1: -32768, s0: 32767,
               s1: -32768, gap: 0, stall: 0, hold: 0, bb: 1};
    tbl[2] = '{wv: 1, w0: 1, w1: -1, b0: 3, b1: -3, e0: 39, e1: -39, s0: 9, s1: -10,
               gap: 0, stall: 0, hold: 1, bb: 1};
    tbl[3] = '{wv: 1, w0: 1, w1: -1, b0: 0, b1: 0, e0: 36, e1: -36, s0: 9, s1: -9,
               gap: 2, stall: 5, hold: 0, bb: 1};
    tbl[4] = '{wv: -2, w0: 3, w1: -5, b0: 100, b1: -7, e0: -116, e1: 353, s0: -29, s1: 88,
               gap: 0, stall: 0, hold: 0, bb: 1};
    tbl[5] = '{wv: 0, w0: 0, w1: 0, b0: 40000, b1: -40000, e0: 32767, e1: -32768, s0: 10000,
               s1: -10000, gap: 0, stall: 1, hold: 0, bb: 1};

    rst = 1'b1;
    start = 1'b0;
    win_valid = 1'b0;
    win_data = '0;
    wgt_data = '0;
    bias = '0;
    bias_v = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_win_ready", win_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    rst = 1'b0;
    mon_en = 1'b1;

    for (int j = 0; j < 6; j++) begin
      load_uniform(tbl[j].wv, tbl[j].w0, tbl[j].w1, tbl[j].b0, tbl[j].b1);
      e.e0 = relu(tbl[j].e0);
      e.e1 = relu(tbl[j].e1);
      e.s0 = relu(tbl[j].s0);
      e.s1 = relu(tbl[j].s1);
      e.stall = tbl[j].stall;
      e.lat = (tbl[j].gap == 0);
      exp_q.push_back(e);
      drive_pixel(NCH, tbl[j].gap, tbl[j].hold, tbl[j].bb);
    end

    for (int j = 0; j < 5; j++) begin
      load_random();
      push_model(int'($urandom_range(0, 2)));
      drive_pixel(NCH, 0, 1'b0, 1'b1);
    end
    drain();

    // Abort a pixel after two beats; nothing of it may survive.
    load_uniform(8'sd5, 8'sd7, 8'sd7, 1000, 1000);
    drive_pixel(2, 0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_win_ready", win_ready, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_out_data_s2", out_data_s2, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    load_uniform(8'sd1, 8'sd1, -8'sd1, 0, 0);
    push_model(0);
    drive_pixel(NCH, 0, 1'b0, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
